// File: rtl/display_pkg.sv
// Shared constants and FSM state type for the display controller and the
// benches of the downstream seven-segment driver.
package display_pkg;

  localparam int BIN_W   = 14;
  localparam int MAX_VAL = 9999;
  localparam int N_SHIFT = 14;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

endpackage

// File: rtl/dabble_step.sv
// One BCD digit's add-3 correction, applied before each double-dabble shift.
module dabble_step (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // Digits of 5 or more would overflow a BCD digit when doubled.
  always_comb begin
    q = (d >= 4'd5) ? d + 4'd3 : d;
  end

endmodule

// File: rtl/display_ctrl.sv
// Two-source round-robin binary-to-BCD converter feeding the seven-segment
// driver. A captured value is saturated to MAX_VAL, converted by serial
// double dabble (one bit per cycle), then published with a one-cycle ready.
module display_ctrl #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [BIN_W-1:0] bin_a,
  input  logic             req_b,
  input  logic [BIN_W-1:0] bin_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             busy,
  output logic [3:0]       unidades_out,
  output logic [3:0]       decenas_out,
  output logic [3:0]       centenas_out,
  output logic [3:0]       millares_out,
  output logic             ready,
  output logic             ovf
);

  import display_pkg::*;

  localparam int SR_W = 16 + BIN_W;

  state_t            state;
  logic [3:0]        cnt;
  logic              last_b;
  logic              ovf_pend;
  logic [SR_W-1:0]   sr;
  logic [SR_W-1:0]   sr_nxt;
  logic [3:0]        c0, c1, c2, c3;
  logic              grant_b;
  logic [BIN_W-1:0]  cap_val;
  logic              cap_over;

  function automatic logic over_max(input logic [BIN_W-1:0] v);
    return v > BIN_W'(MAX_VAL);
  endfunction

  function automatic logic [BIN_W-1:0] sat_val(input logic [BIN_W-1:0] v);
    return over_max(v) ? BIN_W'(MAX_VAL) : v;
  endfunction

  // Round-robin grant: B wins a tie unless B was served last.
  always_comb begin
    grant_b  = req_b && (!req_a || !last_b);
    cap_val  = grant_b ? bin_b : bin_a;
    cap_over = over_max(cap_val);
  end

  dabble_step u_step0 (.d(sr[BIN_W +: 4]),      .q(c0));
  dabble_step u_step1 (.d(sr[BIN_W + 4 +: 4]),  .q(c1));
  dabble_step u_step2 (.d(sr[BIN_W + 8 +: 4]),  .q(c2));
  dabble_step u_step3 (.d(sr[BIN_W + 12 +: 4]), .q(c3));

  // Correct all digits, then shift the binary MSB into the BCD field.
  always_comb begin
    sr_nxt = {c3, c2, c1, c0, sr[BIN_W-1:0]} << 1;
  end

  // Conversion datapath: preload while idle, shift one bit per CONV cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      sr       <= {16'd0, sat_val(cap_val)};
      ovf_pend <= cap_over;
    end else if (state == CONV) begin
      sr <= sr_nxt;
    end
  end

  // Control FSM with registered handshake, status and display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      last_b       <= 1'b0;
      ack_a        <= 1'b0;
      ack_b        <= 1'b0;
      busy         <= 1'b0;
      ready        <= 1'b0;
      ovf          <= 1'b0;
      unidades_out <= 4'd0;
      decenas_out  <= 4'd0;
      centenas_out <= 4'd0;
      millares_out <= 4'd0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            state  <= CONV;
            busy   <= 1'b1;
            cnt    <= 4'd0;
            last_b <= grant_b;
            ack_b  <= grant_b;
            ack_a  <= !grant_b;
          end
        end
        CONV: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(N_SHIFT - 1)) begin
            state        <= DONE;
            ready        <= 1'b1;
            ovf          <= ovf_pend;
            unidades_out <= sr_nxt[BIN_W +: 4];
            decenas_out  <= sr_nxt[BIN_W + 4 +: 4];
            centenas_out <= sr_nxt[BIN_W + 8 +: 4];
            millares_out <= sr_nxt[BIN_W + 12 +: 4];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_ctrl.sv
module tb_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_a = 1'b0;
  logic [13:0] bin_a = '0;
  logic        req_b = 1'b0;
  logic [13:0] bin_b = '0;
  logic        ack_a, ack_b, busy, ready, ovf;
  logic [3:0]  unidades_out, decenas_out, centenas_out, millares_out;

  int checks = 0;
  int errors = 0;

  int na = 0;
  int nb = 0;
  bit grants[$];

  display_ctrl dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .bin_a(bin_a), .req_b(req_b), .bin_b(bin_b),
    .ack_a(ack_a), .ack_b(ack_b), .busy(busy),
    .unidades_out(unidades_out), .decenas_out(decenas_out),
    .centenas_out(centenas_out), .millares_out(millares_out),
    .ready(ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Ack monitor, sampled shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    if (ack_a) begin na = na + 1; grants.push_back(1'b0); end
    if (ack_b) begin nb = nb + 1; grants.push_back(1'b1); end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          src;     // 1 = B
    logic [13:0] val;
    logic [15:0] exp_d;   // {millares, centenas, decenas, unidades}
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] digits();
    return {millares_out, centenas_out, decenas_out, unidades_out};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    if (busy) chk({nm, " idle timeout"}, 1, 0);
  endtask

  // Called at the negedge of the first cycle after capture; returns the
  // cycle index (relative to capture) at which ready was seen.
  task automatic wait_ready(input string nm, input logic [15:0] hold, output int cyc);
    bit stable;
    cyc = 1;
    stable = 1'b1;
    if (digits() != hold) stable = 1'b0;
    while (!ready && cyc < 40) begin
      tick();
      cyc++;
      if (!ready && digits() != hold) stable = 1'b0;
    end
    chk({nm, " digits stable"}, stable, 1);
  endtask

  task automatic run_conv(input string nm, input bit src, input logic [13:0] val,
                          input logic [15:0] exp_d, input bit exp_ovf);
    logic [15:0] hold;
    int cyc;
    wait_idle(nm);
    hold = digits();
    if (src) begin req_b = 1'b1; bin_b = val; end
    else begin req_a = 1'b1; bin_a = val; end
    tick();
    chk({nm, " ack"}, src ? ack_b : ack_a, 1);
    chk({nm, " other ack"}, src ? ack_a : ack_b, 0);
    chk({nm, " busy"}, busy, 1);
    req_a = 1'b0; req_b = 1'b0;
    wait_ready(nm, hold, cyc);
    chk({nm, " ready cycle"}, cyc, 15);
    chk({nm, " digits"}, digits(), exp_d);
    chk({nm, " ovf"}, ovf, exp_ovf);
  endtask

  initial begin
    int cyc, n, na0, nb0, s0;
    bit seen;

    vecs[0]  = '{1'b0, 14'd7609,  16'h7609, 1'b0};
    vecs[1]  = '{1'b1, 14'd94,    16'h0094, 1'b0};
    vecs[2]  = '{1'b0, 14'd12000, 16'h9999, 1'b1};
    vecs[3]  = '{1'b0, 14'd0,     16'h0000, 1'b0};
    vecs[4]  = '{1'b1, 14'd9999,  16'h9999, 1'b0};
    vecs[5]  = '{1'b0, 14'd10000, 16'h9999, 1'b1};
    vecs[6]  = '{1'b1, 14'd16383, 16'h9999, 1'b1};
    vecs[7]  = '{1'b0, 14'd1,     16'h0001, 1'b0};
    vecs[8]  = '{1'b1, 14'd1000,  16'h1000, 1'b0};
    vecs[9]  = '{1'b0, 14'd5555,  16'h5555, 1'b0};
    vecs[10] = '{1'b1, 14'd8642,  16'h8642, 1'b0};
    vecs[11] = '{1'b0, 14'd4095,  16'h4095, 1'b0};

    // Reset state
    do_reset();
    chk("rst digits", digits(), 16'h0000);
    chk("rst ovf", ovf, 0);
    chk("rst ready", ready, 0);
    chk("rst busy", busy, 0);
    chk("rst acks", {ack_a, ack_b}, 0);

    // Simultaneous requests after reset: B first, then pending A
    na0 = na; nb0 = nb;
    req_a = 1'b1; bin_a = 14'd3193;
    req_b = 1'b1; bin_b = 14'd94;
    tick();
    chk("sim first ack_b", ack_b, 1);
    chk("sim first ack_a", ack_a, 0);
    req_b = 1'b0;
    wait_ready("sim B", 16'h0000, cyc);
    chk("sim B ready cycle", cyc, 15);
    chk("sim B digits", digits(), 16'h0094);
    n = 0;
    while (!ack_a && n < 10) begin tick(); n++; end
    chk("sim A ack delay", n, 2);
    req_a = 1'b0;
    wait_ready("sim A", 16'h0094, cyc);
    chk("sim A ready cycle", cyc, 15);
    chk("sim A digits", digits(), 16'h3193);
    wait_idle("sim");
    chk("sim ack_a count", na - na0, 1);
    chk("sim ack_b count", nb - nb0, 1);

    // Both held: grants alternate B, A, B
    do_reset();
    s0 = grants.size();
    req_a = 1'b1; bin_a = 14'd3193;
    req_b = 1'b1; bin_b = 14'd94;
    n = 0;
    while (grants.size() - s0 < 3 && n < 100) begin tick(); n++; end
    req_a = 1'b0; req_b = 1'b0;
    wait_idle("alt");
    tick();
    chk("alt grant count", grants.size() - s0, 3);
    if (grants.size() - s0 >= 3) begin
      chk("alt grant 0", grants[s0], 1);
      chk("alt grant 1", grants[s0+1], 0);
      chk("alt grant 2", grants[s0+2], 1);
    end
    chk("alt final digits", digits(), 16'h0094);

    // Table of single-source conversions
    for (int i = 0; i < 12; i++) begin
      run_conv($sformatf("vec%0d", i), vecs[i].src, vecs[i].val,
               vecs[i].exp_d, vecs[i].exp_ovf);
    end

    // Reset at CONV cycle 7 aborts the conversion
    wait_idle("abort");
    req_a = 1'b1; bin_a = 14'd4321;
    tick();
    chk("abort ack", ack_a, 1);
    req_a = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort digits", digits(), 16'h0000);
    chk("abort ovf", ovf, 0);
    seen = 1'b0;
    repeat (20) begin
      if (ready) seen = 1'b1;
      tick();
    end
    chk("abort no ready", seen, 0);

    // Reset wins over a simultaneous request, which is served afterwards
    req_a = 1'b1; bin_a = 14'd4321;
    rst = 1'b1;
    tick();
    chk("rstprio ack_a", ack_a, 0);
    chk("rstprio busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("rstprio later ack_a", ack_a, 1);
    req_a = 1'b0;
    wait_ready("rstprio", 16'h0000, cyc);
    chk("rstprio ready cycle", cyc, 15);
    chk("rstprio digits", digits(), 16'h4321);
    tick();
    chk("ready one cycle", ready, 0);
    chk("busy after done", busy, 1'b0);
    chk("digits hold", digits(), 16'h4321);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 Parameter BIN_W, default 14, binary operand width; values other than 14 are unsupported.
REQ-002 Parameter MAX_VAL, default 9999, largest displayable value.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_a  input  1  entry-value requester (keypad operand); held high until ack_a.
REQ-006 bin_a  input  BIN_W  entry value, unsigned binary; stable while req_a high.
REQ-007 req_b  input  1  result-value requester (arithmetic result); held high until ack_b.
REQ-008 bin_b  input  BIN_W  result value, unsigned binary; stable while req_b high.
REQ-009 ack_a, ack_b  output  1 each  one-cycle grant/capture acknowledge.
REQ-010 busy  output  1  conversion or update in progress.
REQ-011 unidades_out, decenas_out, centenas_out, millares_out  output  4 each  BCD digits to sevenseg_driver.
REQ-012 ready  output  1  one-cycle pulse; digits valid, sevenseg_driver latches them.
REQ-013 ovf  output  1  last displayed value was saturated.

Function
REQ-014 The FSM SHALL have states IDLE, CONV, DONE; every output SHALL be registered.
REQ-015 In IDLE, at an edge where req_a or req_b is high, the block SHALL capture the granted value, enter CONV, and assert the matching ack for exactly the following cycle.
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the source not served last; with one request high, grant it.
REQ-017 After reset the last-served pointer SHALL be A, so B wins the first simultaneous request.
REQ-018 A captured value greater than MAX_VAL SHALL be replaced by 9999 before conversion, with ovf set to 1; otherwise ovf SHALL be set to 0.
REQ-019 CONV SHALL perform shift-and-add-3 (double dabble) over exactly 14 cycles, one bit per cycle, MSB first.
REQ-020 The add-3 correction SHALL be applied to every BCD digit >= 5 before each shift.
REQ-021 At the edge ending the 14th CONV cycle, the four digit outputs and ovf SHALL update together, and the FSM SHALL enter DONE.
REQ-022 ready SHALL be high only during DONE, for exactly one cycle, which is the 15th cycle after the capture edge.
REQ-023 DONE SHALL always return to IDLE, and the next capture SHALL occur no earlier than the edge after the one leaving DONE.
REQ-024 busy SHALL be high throughout CONV and DONE, and low in IDLE.
REQ-025 Requests arriving while busy SHALL be held pending, neither lost nor acked early.
REQ-026 A request dropped before its ack SHALL be ignored.
REQ-027 Digit outputs and ovf SHALL hold their values between ready pulses.
REQ-028 An input value of 0 SHALL yield digits 0,0,0,0.

Reset
REQ-029 With rst high at an edge, the block SHALL enter IDLE and clear the digits, ovf, ready, ack_a, ack_b and busy to 0, and reset the pointer to A.
REQ-030 Reset during CONV or DONE SHALL abort the operation: no ready pulse, and the displayed digits are cleared to 0.
REQ-031 Reset SHALL take priority over a simultaneous request.

Structure
REQ-032 Package display_pkg SHALL hold the FSM state enum, BIN_W, MAX_VAL and N_SHIFT=14, shared with sevenseg_driver benches.
REQ-033 The combinational per-digit add-3 correction SHALL be the sub-module dabble_step, instantiated four times.
REQ-034 The implementation target is 120-400 lines of RTL.

Verification
REQ-035 After reset, req_a with bin_a=7609 -> ack_a one cycle after capture; ready 15 cycles after capture; digits 7,6,0,9; ovf=0.
REQ-036 req_a (3193) and req_b (94) raised in the same cycle -> B served first (0,0,9,4 with ready), then A (3,1,9,3 with a second ready); exactly one ack each.
REQ-037 req_b held high continuously while req_a is pending -> grants alternate B, A, B.
REQ-038 bin_a=12000 -> digits 9,9,9,9 and ovf=1; a following bin_a=0 -> 0,0,0,0 and ovf=0.
REQ-039 rst pulsed at CONV cycle 7 of value 4321 -> no ready pulse; digits 0; busy low next cycle; a fresh request then converts correctly.
REQ-040 req_a raised while busy -> ack_a held off until IDLE, then captured; digits remain stable between ready pulses.
